// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and default sizing for the sequential ALU.
package alu_pkg;
  localparam int OP_W      = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MULU = 4'b1010,
    OP_DIVU = 4'b1011
  } op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between the EX stage and the ALU.
interface seq_alu_if import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, op, A, B, shamt, out_ready,
    input  in_ready, out_valid, result, hi, zero, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, op, A, B, shamt, out_ready,
    output in_ready, out_valid, result, hi, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic             div_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // hi_r doubles as the multiply accumulator and the divide remainder; lo_r as
  // the multiplier and the quotient being shifted in.
  always_comb begin
    sum    = {1'b0, hi_r} + {1'b0, b_r};
    rem_sh = {hi_r, lo_r[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_r};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_r <= 1'b0;
      b_r   <= '0;
      lo_r  <= '0;
      hi_r  <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      div_r <= is_div;
      b_r   <= b;
      lo_r  <= a;
      hi_r  <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (div_r) begin
        if (!diff[WIDTH]) begin
          hi_r <= diff[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b1};
        end else begin
          hi_r <= rem_sh[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b0};
        end
      end else if (lo_r[0]) begin
        {hi_r, lo_r} <= {sum, lo_r[WIDTH-1:1]};
      end else begin
        {hi_r, lo_r} <= {1'b0, hi_r, lo_r[WIDTH-1:1]};
      end
    end
  end

  assign done = (cnt == CW'(1));
  assign lo   = lo_r;
  assign hi   = hi_r;
endmodule

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: single-cycle ops plus iterative MULU/DIVU.
//   state | meaning
//   IDLE  | ready for an op; operands latched on in_valid
//   BUSY  | muldiv engine iterating, one bit per cycle
//   DONE  | result presented, held until out_ready
module seq_alu import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  seq_alu_if.slave bus
);
  state_e           state, state_nxt;
  op_e              op_in;
  logic [SHW-1:0]   sh;
  logic             accept, is_md, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [WIDTH-1:0] sc_result, sc_hi;
  logic             sc_ovf, sc_dbz;
  logic [WIDTH-1:0] result_r, hi_r, res;
  logic             ovf_r, dbz_r, sel_md_r;

  assign op_in = op_e'(bus.op);
  assign sh    = bus.shamt;
  assign is_md = (op_in == OP_MULU) || ((op_in == OP_DIVU) && (bus.B != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = is_md ? BUSY : DONE;
      BUSY: if (md_done)      state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    accept        = (state == IDLE) && bus.in_valid;
    md_start      = accept && is_md;
  end

  always_comb begin
    sc_result = bus.A;
    sc_hi     = '0;
    sc_ovf    = 1'b0;
    sc_dbz    = 1'b0;
    case (op_in)
      OP_ADD: begin
        sc_result = bus.A + bus.B;
        sc_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sc_result[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = bus.A - bus.B;
        sc_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sc_result[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  sc_result = bus.A & bus.B;
      OP_OR:   sc_result = bus.A | bus.B;
      OP_XOR:  sc_result = bus.A ^ bus.B;
      OP_SLL:  sc_result = bus.A << sh;
      OP_SRL:  sc_result = bus.A >> sh;
      OP_SRA:  sc_result = $signed(bus.A) >>> sh;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      OP_DIVU: begin
        // Only reaches here as a result when B is zero; otherwise the engine owns it.
        sc_result = '1;
        sc_hi     = bus.A;
        sc_dbz    = (bus.B == '0);
      end
      default: sc_result = bus.A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r <= '0;
      hi_r     <= '0;
      ovf_r    <= 1'b0;
      dbz_r    <= 1'b0;
      sel_md_r <= 1'b0;
    end else if (accept) begin
      result_r <= sc_result;
      hi_r     <= sc_hi;
      ovf_r    <= sc_ovf;
      dbz_r    <= sc_dbz;
      sel_md_r <= is_md;
    end
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (op_in == OP_DIVU),
    .a      (bus.A),
    .b      (bus.B),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // zero is qualified by DONE so the reset state reports all flags low.
  assign res             = sel_md_r ? md_lo : result_r;
  assign bus.result      = res;
  assign bus.hi          = sel_md_r ? md_hi : hi_r;
  assign bus.zero        = (state == DONE) && (res == '0);
  assign bus.overflow    = ovf_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU.
- Single-cycle ops: add/sub/logic/shift/compare.
- Multi-cycle ops: iterative unsigned multiply and divide, producing HI/LO results.
- Sits in EX stage; the pipeline stalls on in_ready/out_valid instead of assuming one-cycle results.

Parameters:
WIDTH, 32, operand/result width (>=8, power of 2)
SHW, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operation presented
in_ready  out  1  ALU can accept an operation
op  in  4  operation code (alu_pkg)
A  in  WIDTH  operand A
B  in  WIDTH  operand B
shamt  in  SHW  shift amount for SLL/SRL/SRA
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  primary result (LO for MULU/DIVU)
hi  out  WIDTH  MULU high product / DIVU remainder; 0 for other ops
zero  out  1  result == 0
overflow  out  1  signed overflow (ADD/SUB only)
div_by_zero  out  1  DIVU with B == 0

Behaviour:
- Reset (rst_n low at posedge): state IDLE; in_ready=1; out_valid=0; result, hi, zero, overflow, div_by_zero all 0. Reset wins over every other event, including mid-BUSY and in DONE; an in-flight op is discarded.
- Op codes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA (all by shamt).
  - 1000 SLT (signed compare, result 1/0); 1001 SLTU.
  - 1010 MULU; 1011 DIVU.
  - Any other code: result=A (pass-through), single-cycle.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid, latch op, A, B, shamt.
    - Single-cycle op: compute result, go to DONE next cycle (latency 1).
    - MULU/DIVU: go to BUSY with counter=WIDTH.
  - BUSY: in_ready=0. One iteration per cycle; counter decrements. When counter reaches 1, the final iteration completes and the FSM goes to DONE. MULU/DIVU latency = WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1; outputs held stable until out_ready=1, then return to IDLE. in_ready=0 in DONE. Max throughput is one op per 2 cycles; the same-cycle re-accept in DONE is deferred to a later generation.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = sign(A) and sign(B or ~B) equal and differ from sign(result). overflow is 0 for all other ops.
- Shifts: SRA replicates A[WIDTH-1]. shamt=0 passes A through unchanged.
- MULU:
  - Shift-add algorithm, unsigned, 2*WIDTH-bit product.
  - result=LO, hi=HI.
- DIVU:
  - Restoring algorithm, unsigned; result=quotient, hi=remainder.
  - B==0 skips BUSY and goes directly to DONE in 1 cycle: result all ones, hi=A, div_by_zero=1.
- Flags:
  - zero is evaluated on result only (not hi) for every op.
  - div_by_zero is 0 except in that case.
- Input changes while not in IDLE are ignored, since operands are latched.

Decomposition:
- alu_pkg:
  - op_e enum (codes above).
  - state_e {IDLE, BUSY, DONE}.
  - Constants OP_W=4 and the default WIDTH.
- Sub-module seq_muldiv:
  - Iterative MULU/DIVU engine with start, is_div, a, b inputs and done, lo, hi outputs.
  - Owns the counter and partial registers.
  - seq_alu keeps the FSM, the combinational single-cycle datapath and the flags.

Test Plan:
- ADD A=5,B=7, out_ready=1 → out_valid 1 cycle after accept, result=12, zero=0, overflow=0; in_ready low in DONE.
- SUB A=0x7FFFFFFF,B=0xFFFFFFFF → result=0x80000000, overflow=1.
- SUB A=9,B=9 → result=0, zero=1.
- SRA A=0x80000000,shamt=4 → result=0xF8000000.
- SLT A=-1,B=1 → result=1; SLTU → result=0.
- MULU A=0xFFFFFFFF,B=2 → out_valid exactly 33 cycles after accept, hi=1, result=0xFFFFFFFE.
- DIVU A=100,B=7 → result=14, hi=2, latency 33.
- DIVU B=0, A=0x1234 → 1-cycle latency, result=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable and no new op accepted despite in_valid=1. Release → IDLE, then next op accepted.
- Reset mid-BUSY: assert rst_n=0 at cycle 10 of a MULU → next cycle state IDLE, out_valid=0, all outputs 0. A fresh ADD then completes normally.
